jtframe_sdram_arbiter: RTL

- Shares the single game-side SDRAM read port (sdram_req/sdram_ack/sdram_addr/sdram_bank/data_read/data_rdy) between NSLOT independent ROM requesters.
- Sits between the game's ROM fetchers and the board SDRAM controller; one read is outstanding at a time.
- Uses round-robin priority with a per-transaction watchdog.
- Blocks all grants while a download is in progress or the controller loop is in reset.

---
 rtl/jtframe_sdram_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among NSLOT ROM requesters, one read in flight.
// Grant is registered (sdram_req one cycle after slot_req); stalls on sdram_ack/data_rdy, watchdog aborts stuck reads.
module jtframe_sdram_arbiter #(
  parameter int NSLOT = 4,
  parameter int AW    = 22,
  parameter int TOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic               loop_rst,
  input  logic [NSLOT-1:0]   slot_req,
  input  logic [NSLOT*AW-1:0] slot_addr,
  input  logic [NSLOT*2-1:0] slot_bank,
  output logic [NSLOT-1:0]   slot_ack,
  output logic [NSLOT-1:0]   slot_dok,
  output logic [31:0]        slot_data,
  output logic               sdram_req,
  output logic [AW-1:0]      sdram_addr,
  output logic [1:0]         sdram_bank,
  input  logic               sdram_ack,
  input  logic [31:0]        data_read,
  input  logic               data_rdy,
  output logic               timeout
);

  localparam int              PW   = $clog2(NSLOT);
  localparam logic [7:0]      TLIM = 8'(TOUT - 1);
  localparam logic [PW-1:0]   LAST = PW'(NSLOT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           st;
  logic [PW-1:0]    ptr, gnt, sel, idx, nxt;
  logic             sel_vld;
  logic [7:0]       wdog;
  logic [NSLOT-1:0] gnt_oh;
  logic [AW-1:0]    addr_a [NSLOT];
  logic [1:0]       bank_a [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
    assign addr_a[g] = slot_addr[g*AW +: AW];
    assign bank_a[g] = slot_bank[g*2 +: 2];
  end

  assign gnt_oh = NSLOT'(1) << gnt;
  assign nxt    = (gnt == LAST) ? '0 : gnt + 1'b1;

  // Scan from the highest offset down so the slot closest above ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel     = ptr;
    idx     = '0;
    for (int k = NSLOT-1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NSLOT);
      if (slot_req[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || loop_rst) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_bank <= '0;
      slot_ack   <= '0;
      slot_dok   <= '0;
      slot_data  <= '0;
      ptr        <= '0;
      gnt        <= '0;
      wdog       <= '0;
      if (rst) timeout <= 1'b0;
    end else begin
      slot_ack <= '0;
      slot_dok <= '0;
      case (st)
        IDLE: if (!downloading && sel_vld) begin
          gnt        <= sel;
          sdram_addr <= addr_a[sel];
          sdram_bank <= bank_a[sel];
          sdram_req  <= 1'b1;
          wdog       <= '0;
          st         <= REQ;
        end
        REQ: begin
          wdog <= wdog + 8'd1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            slot_ack  <= gnt_oh;
            if (data_rdy) begin
              slot_data <= data_read;
              slot_dok  <= gnt_oh;
              st        <= DONE;
            end else begin
              st <= WAIT;
            end
          end else if (wdog == TLIM) begin
            sdram_req <= 1'b0;
            timeout   <= 1'b1;
            ptr       <= nxt;
            st        <= IDLE;
          end
        end
        WAIT: begin
          wdog <= wdog + 8'd1;
          if (data_rdy) begin
            slot_data <= data_read;
            slot_dok  <= gnt_oh;
            st        <= DONE;
          end else if (wdog == TLIM) begin
            timeout <= 1'b1;
            ptr     <= nxt;
            st      <= IDLE;
          end
        end
        DONE: begin
          ptr <= nxt;
          st  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
